foct_sq_demod: RTL and testbench
================================

Name: foct_sq_demod

Overview:
- Square-wave demodulator for the closed-loop FOCT chain.
- Sits directly downstream of the AD7655 driver and consumes its photodetector channel word (Current_Info) plus a one-cycle sample strobe.
- Sums N settled samples in the positive modulation half-period and N in the negative half, then outputs their difference once per modulation period.
- The output is the phase-error term for the downstream loop controller.

Parameters:
- SAMPLE_W, 16: ADC word width.
- LOG2_NAVG, 4: log2 of samples accumulated per half-period (N = 16).
- DISCARD, 2: samples dropped after each phase edge for settling.
- OUT_W, 21: Demod_Out width, equal to SAMPLE_W + LOG2_NAVG + 1.

Ports:
- Clk_100M  in  1  system clock.
- SYS_RST  in  1  synchronous, active-high reset.
- Enable  in  1  demodulation enable; low forces IDLE.
- Sample_Valid  in  1  one-cycle strobe; Sample_Data is new this cycle.
- Sample_Data  in  16  AD7655 word, straight binary.
- Mod_Phase  in  1  modulation phase, synchronous to Clk_100M (1 = positive half).
- Demod_Out  out  21  signed sum_pos - sum_neg.
- Demod_Valid  out  1  one-cycle pulse when Demod_Out updates.
- Sync_Err  out  1  sticky flag: frame aborted by an early phase edge.

Behaviour:
- Reset and output values:
  - Reset value of all outputs is 0. Accumulators, counters and phase register clear. State = IDLE.
  - Reset mid-frame discards all partial sums.
- Sample conversion: signed = {~Sample_Data[15], Sample_Data[14:0]}, then sign-extended to OUT_W. 0x8000 maps to 0; 0x0000 maps to -32768.
- Phase edge detection: Mod_Phase is registered once (ph_d).
  - rise = Mod_Phase & ~ph_d
  - fall = ~Mod_Phase & ph_d
- States: IDLE, SETTLE_P, ACC_P, WAIT_P, SETTLE_N, ACC_N, WAIT_N.
  - IDLE: wait for rise, then go to SETTLE_P with cnt = 0 and acc_p = acc_n = 0. Samples are ignored.
  - SETTLE_x: each Sample_Valid increments cnt. When DISCARD samples are counted, go to ACC_x with cnt = 0.
  - ACC_x: each Sample_Valid adds the converted sample to acc_x and increments cnt. On the N-th sample, go to WAIT_x.
  - WAIT_P: samples are ignored. On fall, go to SETTLE_N with cnt = 0.
  - WAIT_N: samples are ignored. On rise, go to SETTLE_P with cnt = 0 and acc_p = acc_n = 0.
  - End of frame: the N-th sample in ACC_N completes the frame.
    - At the next clock edge, Demod_Out <= acc_p - acc_n and Demod_Valid = 1 for exactly one cycle.
    - Latency: 2 clock edges from the strobe of the last negative sample.
- Early phase edge:
  - Trigger: an edge opposite to the current half arrives while in SETTLE_x or ACC_x.
  - Response: Sync_Err <= 1, partial sums are dropped, no Demod_Valid is issued.
  - Recovery: if the edge is a rise, go directly to SETTLE_P (fresh frame). Otherwise go to IDLE.
  - Sync_Err clears only on SYS_RST.
- Simultaneous Sample_Valid and phase edge: the sample belongs to the new phase and counts as that phase's first discard sample.
- Phase edge in WAIT_x in the same cycle the state is entered: handled as in WAIT_x.
- Enable low: go to IDLE next edge and clear partial sums. Demod_Out holds its last value; Demod_Valid = 0; Sync_Err holds.
- Arithmetic width: acc_x is OUT_W-1 = 20 bits signed and cannot overflow (16 x ±32768 fits). The difference is OUT_W signed with no saturation needed.
- Pulse spacing: Demod_Valid never asserts on consecutive cycles.

Decomposition:
- Shared package (foct_pkg):
  - State encoding constants.
  - SAMPLE_W, LOG2_NAVG, OUT_W.
  - Offset-binary-to-signed conversion function, reused by TEMP/MOD consumers.
- Sub-module phase_accum, instantiated twice (pos/neg):
  - Inputs: clr, en, Sample_Valid, sample.
  - Outputs: acc, done (N reached).
- The top level holds the edge detector, FSM, subtractor and output registers.

Test Plan:
- Nominal frame (default params): rise, then 18 strobes of 0x9000, then fall, then 18 strobes of 0x7000 → single Demod_Valid pulse with Demod_Out = 0x20000 (+131072); Sync_Err = 0.
- Settle discard: first 2 samples of each half = 0xFFFF, remaining 16 = 0x8000 → Demod_Out = 0.
- Early edge: fall after only 10 positive samples → Sync_Err = 1, no Demod_Valid. The next full rise/fall frame of 0x8100 / 0x8000 gives Demod_Out = 16 x 256 = 4096.
- Extremes: positive half all 0xFFFF, negative half all 0x0000 → Demod_Out = 16 x 32767 + 16 x 32768 = 1048560; no wrap.
- Coincident events and enable drop:
  - Sample_Valid in the same cycle as rise → that sample is discarded.
  - Enable low mid-ACC_N → no pulse, Demod_Out holds the previous value, IDLE until the next rise.
- Reset: SYS_RST for 1 cycle mid-ACC_P → all outputs 0 next cycle and Sync_Err cleared; a subsequent full frame still produces the correct result.

Source files
------------

// File: rtl/foct_pkg.sv
// rtl/foct_pkg.sv - shared widths, demodulator state encoding and ADC word conversion
package foct_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int LOG2_NAVG = 4;
    localparam int OUT_W     = SAMPLE_W + LOG2_NAVG + 1;
    localparam int ACC_W     = OUT_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_P,
        ACC_P,
        WAIT_P,
        SETTLE_N,
        ACC_N,
        WAIT_N
    } demod_state_t;

    // Offset-binary ADC word to two's complement: 0x8000 -> 0, 0x0000 -> -32768.
    function automatic logic signed [OUT_W-1:0] ob_to_signed(input logic [SAMPLE_W-1:0] word);
        return {{(OUT_W-SAMPLE_W){~word[SAMPLE_W-1]}}, ~word[SAMPLE_W-1], word[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/phase_accum.sv
// rtl/phase_accum.sv - accumulates 2**LOG2_NAVG signed samples of one modulation half
module phase_accum
    import foct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    sample_valid,
    input  logic signed [OUT_W-1:0] sample,
    output logic signed [ACC_W-1:0] acc,
    output logic                    done
);

    logic [LOG2_NAVG-1:0] cnt;
    logic                 take;

    assign take = en && sample_valid;
    // The counter wraps to zero on the last sample, so it is ready for the next frame.
    assign done = take && (cnt == '1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            acc <= acc + ACC_W'(sample);
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/foct_sq_demod.sv
// rtl/foct_sq_demod.sv - square-wave demodulator: sum_pos - sum_neg once per modulation period
module foct_sq_demod
    import foct_pkg::*;
#(
    parameter int DISCARD = 2
) (
    input  logic                    Clk_100M,
    input  logic                    SYS_RST,
    input  logic                    Enable,
    input  logic                    Sample_Valid,
    input  logic [SAMPLE_W-1:0]     Sample_Data,
    input  logic                    Mod_Phase,
    output logic signed [OUT_W-1:0] Demod_Out,
    output logic                    Demod_Valid,
    output logic                    Sync_Err
);

    localparam int CNT_W = 4;

    demod_state_t            state;
    logic [CNT_W-1:0]        cnt;
    logic                    ph_d;
    logic                    frame_done;
    logic                    rise, fall;
    logic                    in_pos, in_neg;
    logic                    start_p, clr_acc;
    logic                    en_p, en_n, done_p, done_n;
    logic                    edge_skip, settle_last;
    logic [CNT_W-1:0]        edge_cnt;
    logic signed [OUT_W-1:0] sample_s;
    logic signed [ACC_W-1:0] acc_p, acc_n;

    assign sample_s = ob_to_signed(Sample_Data);
    assign rise     = Mod_Phase & ~ph_d;
    assign fall     = ~Mod_Phase & ph_d;
    assign in_pos   = (state == SETTLE_P) || (state == ACC_P);
    assign in_neg   = (state == SETTLE_N) || (state == ACC_N);

    // Any accepted rise starts a fresh frame, including one that aborts a negative half.
    assign start_p  = Enable && rise && !in_pos && (state != WAIT_P);
    assign clr_acc  = !Enable || start_p || (in_pos && fall);
    assign en_p     = (state == ACC_P) && !fall;
    assign en_n     = (state == ACC_N) && !rise;

    // A strobe coincident with a phase edge is the new half's first discard sample.
    assign edge_skip   = Sample_Valid && (DISCARD == 1);
    assign edge_cnt    = (Sample_Valid && !edge_skip) ? CNT_W'(1) : '0;
    assign settle_last = (cnt == CNT_W'(DISCARD - 1));

    phase_accum u_pos (
        .clk          (Clk_100M),
        .rst          (SYS_RST),
        .clr          (clr_acc),
        .en           (en_p),
        .sample_valid (Sample_Valid),
        .sample       (sample_s),
        .acc          (acc_p),
        .done         (done_p)
    );

    phase_accum u_neg (
        .clk          (Clk_100M),
        .rst          (SYS_RST),
        .clr          (clr_acc),
        .en           (en_n),
        .sample_valid (Sample_Valid),
        .sample       (sample_s),
        .acc          (acc_n),
        .done         (done_n)
    );

    always_ff @(posedge Clk_100M) begin
        if (SYS_RST) begin
            state       <= IDLE;
            cnt         <= '0;
            ph_d        <= 1'b0;
            frame_done  <= 1'b0;
            Demod_Out   <= '0;
            Demod_Valid <= 1'b0;
            Sync_Err    <= 1'b0;
        end else begin
            ph_d        <= Mod_Phase;
            frame_done  <= 1'b0;
            Demod_Valid <= 1'b0;

            if (frame_done && Enable) begin
                Demod_Out   <= OUT_W'(acc_p) - OUT_W'(acc_n);
                Demod_Valid <= 1'b1;
            end

            if (!Enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE, WAIT_N: begin
                        if (rise) begin
                            state <= edge_skip ? ACC_P : SETTLE_P;
                            cnt   <= edge_cnt;
                        end
                    end
                    WAIT_P: begin
                        if (fall) begin
                            state <= edge_skip ? ACC_N : SETTLE_N;
                            cnt   <= edge_cnt;
                        end
                    end
                    SETTLE_P: begin
                        if (fall) begin
                            Sync_Err <= 1'b1;
                            state    <= IDLE;
                            cnt      <= '0;
                        end else if (Sample_Valid) begin
                            if (settle_last) begin
                                state <= ACC_P;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ACC_P: begin
                        if (fall) begin
                            Sync_Err <= 1'b1;
                            state    <= IDLE;
                            cnt      <= '0;
                        end else if (done_p) begin
                            state <= WAIT_P;
                        end
                    end
                    SETTLE_N: begin
                        if (rise) begin
                            Sync_Err <= 1'b1;
                            state    <= edge_skip ? ACC_P : SETTLE_P;
                            cnt      <= edge_cnt;
                        end else if (Sample_Valid) begin
                            if (settle_last) begin
                                state <= ACC_N;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ACC_N: begin
                        if (rise) begin
                            Sync_Err <= 1'b1;
                            state    <= edge_skip ? ACC_P : SETTLE_P;
                            cnt      <= edge_cnt;
                        end else if (done_n) begin
                            state      <= WAIT_N;
                            frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_foct_sq_demod.sv
// tb/tb_foct_sq_demod.sv - self-checking bench for foct_sq_demod against a frame-level sum model
module tb_foct_sq_demod;

    localparam int DISC = 2;
    localparam int NAVG = 16;

    logic               clk = 1'b0;
    logic               rst, enable, sample_valid, mod_phase;
    logic [15:0]        sample_data;
    logic signed [20:0] demod_out;
    logic               demod_valid, sync_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0, pulse_cnt = 0, pulse_cyc = 0, consec = 0, last_out = 0;
    logic prev_v = 1'b0;

    logic [15:0] pos_s[20];
    logic [15:0] neg_s[20];
    int          npos, nneg, max_gap, strobe_cyc;
    bit          coinc_p, coinc_n;

    foct_sq_demod dut (
        .Clk_100M     (clk),
        .SYS_RST      (rst),
        .Enable       (enable),
        .Sample_Valid (sample_valid),
        .Sample_Data  (sample_data),
        .Mod_Phase    (mod_phase),
        .Demod_Out    (demod_out),
        .Demod_Valid  (demod_valid),
        .Sync_Err     (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (demod_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
            last_out  <= demod_out;
            if (prev_v) consec <= consec + 1;
        end
        prev_v <= demod_valid;
    end

    // Expected output: positive-half samples minus negative-half samples, settle samples skipped.
    function automatic int model_frame();
        int s = 0;
        for (int i = DISC; i < DISC + NAVG; i++)
            s += (int'(pos_s[i]) - 32768) - (int'(neg_s[i]) - 32768);
        return s;
    endfunction

    task automatic step(input logic v, input logic [15:0] d);
        sample_valid = v;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, max_gap)) step(1'b0, 16'($urandom));
    endtask

    task automatic fill(input logic [15:0] p, input logic [15:0] n);
        for (int i = 0; i < 20; i++) begin
            pos_s[i] = p;
            neg_s[i] = n;
        end
        npos = 18; nneg = 18; coinc_p = 0; coinc_n = 0;
    endtask

    task automatic run_frame();
        int first;
        mod_phase = 1'b1;
        first = coinc_p ? 1 : 0;
        if (coinc_p) step(1'b1, pos_s[0]); else step(1'b0, 16'($urandom));
        for (int i = first; i < npos; i++) begin
            gap();
            step(1'b1, pos_s[i]);
        end
        mod_phase = 1'b0;
        first = coinc_n ? 1 : 0;
        if (coinc_n) step(1'b1, neg_s[0]); else step(1'b0, 16'($urandom));
        for (int i = first; i < nneg; i++) begin
            gap();
            step(1'b1, neg_s[i]);
            if (i == DISC + NAVG - 1) strobe_cyc = cyc;
        end
        repeat (4) step(1'b0, 16'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; mod_phase = 1'b0;
        repeat (2) step(1'b0, 16'hFFFF);
        rst = 1'b0;
        n_checks++;
        if (demod_out !== 21'sd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", demod_out); end
        n_checks++;
        if (demod_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", demod_valid); end
        n_checks++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        repeat (2) step(1'b0, 16'h0);
    endtask

    task automatic test_nominal();
        int p0 = pulse_cnt;
        fill(16'h9000, 16'h7000);
        max_gap = 1;
        run_frame();
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL nominal_pulses: got %0d expected 1", pulse_cnt - p0); end
        n_checks++;
        if (last_out !== 131072) begin n_fail++; $display("FAIL nominal_out: got %0d expected 131072", last_out); end
        n_checks++;
        if (pulse_cyc - strobe_cyc !== 1) begin n_fail++; $display("FAIL nominal_latency: got %0d expected 1", pulse_cyc - strobe_cyc); end
        n_checks++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL nominal_sync_err: got %b expected 0", sync_err); end
    endtask

    task automatic test_settle_discard();
        int p0 = pulse_cnt;
        fill(16'h8000, 16'h8000);
        pos_s[0] = 16'hFFFF; pos_s[1] = 16'hFFFF;
        neg_s[0] = 16'hFFFF; neg_s[1] = 16'hFFFF;
        max_gap = 2;
        run_frame();
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL settle_pulses: got %0d expected 1", pulse_cnt - p0); end
        n_checks++;
        if (last_out !== 0) begin n_fail++; $display("FAIL settle_out: got %0d expected 0", last_out); end
    endtask

    task automatic test_early_edge();
        int p0 = pulse_cnt;
        mod_phase = 1'b1;
        step(1'b0, 16'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'hC000);
        mod_phase = 1'b0;
        step(1'b0, 16'h0);
        for (int i = 0; i < 18; i++) step(1'b1, 16'h1234);
        repeat (3) step(1'b0, 16'h0);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL early_sync_err: got %b expected 1", sync_err); end
        n_checks++;
        if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL early_no_pulse: got %0d expected 0", pulse_cnt - p0); end
        fill(16'h8100, 16'h8000);
        max_gap = 0;
        run_frame();
        n_checks++;
        if (last_out !== 4096 || pulse_cnt - p0 !== 1) begin
            n_fail++; $display("FAIL early_recover: got out %0d pulses %0d expected 4096 and 1", last_out, pulse_cnt - p0);
        end
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL early_sticky: got %b expected 1", sync_err); end
    endtask

    task automatic test_extremes();
        int p0 = pulse_cnt;
        fill(16'hFFFF, 16'h0000);
        max_gap = 1;
        run_frame();
        n_checks++;
        if (last_out !== 1048560 || pulse_cnt - p0 !== 1) begin
            n_fail++; $display("FAIL extremes_out: got out %0d pulses %0d expected 1048560 and 1", last_out, pulse_cnt - p0);
        end
    endtask

    task automatic test_coincident();
        int p0 = pulse_cnt;
        fill(16'h8000, 16'h8000);
        pos_s[0] = 16'hFFFF; pos_s[1] = 16'hFFFF;
        neg_s[0] = 16'h0000; neg_s[1] = 16'h0000;
        for (int i = 2; i < 18; i++) pos_s[i] = 16'h8010;
        coinc_p = 1; coinc_n = 1;
        max_gap = 1;
        run_frame();
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL coinc_pulses: got %0d expected 1", pulse_cnt - p0); end
        n_checks++;
        if (last_out !== 256) begin n_fail++; $display("FAIL coinc_out: got %0d expected 256", last_out); end
    endtask

    task automatic test_enable_drop();
        int p0, exp_prev;
        fill(16'h8400, 16'h7F00);
        max_gap = 0;
        run_frame();
        exp_prev = model_frame();
        p0 = pulse_cnt;
        mod_phase = 1'b1;
        step(1'b0, 16'h0);
        for (int i = 0; i < 18; i++) step(1'b1, 16'hA000);
        mod_phase = 1'b0;
        step(1'b0, 16'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h6000);
        enable = 1'b0;
        repeat (3) step(1'b1, 16'h6000);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, 16'h6000);
        repeat (4) step(1'b0, 16'h0);
        n_checks++;
        if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL enable_no_pulse: got %0d expected 0", pulse_cnt - p0); end
        n_checks++;
        if (demod_out !== 21'(exp_prev)) begin n_fail++; $display("FAIL enable_hold: got %0d expected %0d", demod_out, exp_prev); end
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL enable_sync_hold: got %b expected 1", sync_err); end
        fill(16'h8003, 16'h8001);
        run_frame();
        n_checks++;
        if (last_out !== 32 || pulse_cnt - p0 !== 1) begin
            n_fail++; $display("FAIL enable_recover: got out %0d pulses %0d expected 32 and 1", last_out, pulse_cnt - p0);
        end
    endtask

    task automatic test_reset_mid();
        int p0 = pulse_cnt;
        mod_phase = 1'b1;
        step(1'b0, 16'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'hF000);
        rst = 1'b1; mod_phase = 1'b0;
        step(1'b1, 16'hF000);
        rst = 1'b0;
        n_checks++;
        if (demod_out !== 21'sd0 || demod_valid !== 1'b0 || sync_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got out %0d valid %b sync %b expected 0 0 0", demod_out, demod_valid, sync_err);
        end
        fill(16'h8000, 16'h7FF0);
        max_gap = 1;
        run_frame();
        n_checks++;
        if (last_out !== 256 || pulse_cnt - p0 !== 1) begin
            n_fail++; $display("FAIL reset_recover: got out %0d pulses %0d expected 256 and 1", last_out, pulse_cnt - p0);
        end
    endtask

    task automatic test_random();
        int p0, exp_v;
        for (int f = 0; f < 8; f++) begin
            p0 = pulse_cnt;
            for (int i = 0; i < 20; i++) begin
                pos_s[i] = 16'($urandom);
                neg_s[i] = 16'($urandom);
            end
            npos    = 18 + $urandom_range(0, 2);
            nneg    = 18 + $urandom_range(0, 2);
            coinc_p = bit'($urandom_range(0, 1));
            coinc_n = bit'($urandom_range(0, 1));
            max_gap = $urandom_range(0, 2);
            exp_v   = model_frame();
            run_frame();
            n_checks++;
            if (last_out !== exp_v || pulse_cnt - p0 !== 1) begin
                n_fail++; $display("FAIL random_frame%0d: got out %0d pulses %0d expected %0d and 1", f, last_out, pulse_cnt - p0, exp_v);
            end
            n_checks++;
            if (pulse_cyc - strobe_cyc !== 1) begin
                n_fail++; $display("FAIL random_latency%0d: got %0d expected 1", f, pulse_cyc - strobe_cyc);
            end
        end
        n_checks++;
        if (consec !== 0) begin n_fail++; $display("FAIL pulse_spacing: got %0d back-to-back pulses expected 0", consec); end
    endtask

    initial begin
        sample_valid = 1'b0;
        sample_data  = 16'h0;
        max_gap      = 0;
        test_reset();
        test_nominal();
        test_settle_discard();
        test_early_edge();
        test_extremes();
        test_coincident();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
